// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch stage with wait-state, stall and redirect handling
//
// Purpose: drives one outstanding word request to instruction memory and presents
// the returned instruction (or a bubble) to ID, one instruction per cycle at best.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   pc_stall            ID hazard stall: hold the IF outputs
//   branch_taken        redirect request from EX (wins over pc_stall)
//   branch_target[31:0] redirect address, used as-is
//   im_req, im_addr     instruction memory request and byte address
//   im_ready, im_rdata  response handshake and data (transfer on im_req && im_ready)
//   IF_pc_out           PC of the instruction presented to ID
//   IF_instr_out        instruction presented to ID
//   IF_valid            IF_instr_out is a real instruction (0 = bubble)

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] IF_pc_out,
  output logic [31:0] IF_instr_out,
  output logic        IF_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_if_valid;

  // In DROP the newest branch seen so far decides where fetch resumes,
  // including one arriving on the very cycle the dropped response lands.
  logic [31:0] w_next_redirect;
  logic [31:0] w_pc_plus4;

  assign w_next_redirect = branch_taken ? branch_target : r_redirect_pc;
  assign w_pc_plus4      = r_pc + 32'd4;

  // The address is the PC register itself, so it cannot move while a
  // request waits; HOLD already owns its data and issues nothing.
  assign im_addr      = r_pc;
  assign im_req       = (r_state != HOLD);
  assign IF_pc_out    = r_if_pc;
  assign IF_instr_out = r_if_instr;
  assign IF_valid     = r_if_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_redirect_pc <= 32'd0;
      r_hold_instr  <= 32'd0;
      r_if_pc       <= 32'd0;
      r_if_instr    <= NOP_INSTR;
      r_if_valid    <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (im_ready) begin
            if (branch_taken) begin
              r_pc       <= branch_target;
              r_if_instr <= NOP_INSTR;
              r_if_valid <= 1'b0;
            end else if (pc_stall) begin
              // Data arrived but ID cannot take it: park it, keep pc on it.
              r_hold_instr <= im_rdata;
              r_state      <= HOLD;
            end else begin
              r_if_pc    <= r_pc;
              r_if_instr <= im_rdata;
              r_if_valid <= 1'b1;
              r_pc       <= w_pc_plus4;
            end
          end else begin
            if (branch_taken) begin
              // Request already issued; it must complete before redirecting.
              r_redirect_pc <= branch_target;
              r_if_instr    <= NOP_INSTR;
              r_if_valid    <= 1'b0;
              r_state       <= DROP;
            end else if (!pc_stall) begin
              r_if_instr <= NOP_INSTR;
              r_if_valid <= 1'b0;
            end
          end
        end

        DROP: begin
          r_if_instr <= NOP_INSTR;
          r_if_valid <= 1'b0;
          if (im_ready) begin
            r_pc    <= w_next_redirect;
            r_state <= FETCH;
          end else begin
            r_redirect_pc <= w_next_redirect;
          end
        end

        HOLD: begin
          if (branch_taken) begin
            r_pc       <= branch_target;
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
            r_state    <= FETCH;
          end else if (!pc_stall) begin
            r_if_pc    <= r_pc;
            r_if_instr <= r_hold_instr;
            r_if_valid <= 1'b1;
            r_pc       <= w_pc_plus4;
            r_state    <= FETCH;
          end
        end

        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-003 The block SHALL have port clk, input, 1, the clock.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port pc_stall, input, 1, meaning hold IF outputs (hazard stall from ID).
REQ-006 The block SHALL have port branch_taken, input, 1, meaning redirect the fetch (resolved in EX).
REQ-007 The block SHALL have port branch_target, input, 32, the redirect address.
REQ-008 The block SHALL have port im_req, output, 1, the instruction memory request.
REQ-009 The block SHALL have port im_addr, output, 32, the instruction memory word address (byte address, bits[1:0]=0).
REQ-010 The block SHALL have port im_ready, input, 1, meaning the response is valid; the transfer completes on a cycle with im_req && im_ready.
REQ-011 The block SHALL have port im_rdata, input, 32, the instruction data, valid when im_ready=1.
REQ-012 The block SHALL have port IF_pc_out, output, 32, the PC of the instruction presented to ID.
REQ-013 The block SHALL have port IF_instr_out, output, 32, the instruction presented to ID.
REQ-014 The block SHALL have port IF_valid, output, 1, meaning IF_instr_out is a real instruction (0 = bubble).

Function
REQ-015 The block SHALL have FSM states FETCH, DROP and HOLD, plus registers pc[31:0], redirect_pc[31:0] and hold_instr[31:0].
REQ-016 The block SHALL drive im_addr = pc in all states, with im_req=1 in FETCH and DROP and im_req=0 in HOLD.
REQ-017 The block SHALL hold im_addr stable while im_req=1 and im_ready=0, with at most one outstanding request.
REQ-018 The block SHALL give branch_taken priority over pc_stall in every state.
REQ-019 In FETCH with im_ready=1 and branch_taken=1, the block SHALL set pc<=branch_target, load a bubble (IF_instr_out<=NOP_INSTR, IF_valid<=0), and stay in FETCH.
REQ-020 In FETCH with im_ready=1, branch_taken=0 and pc_stall=1, the block SHALL set hold_instr<=im_rdata, leave the IF registers unchanged, and go to HOLD.
REQ-021 In FETCH with im_ready=1 and no branch or stall, the block SHALL set IF_pc_out<=pc, IF_instr_out<=im_rdata, IF_valid<=1 and pc<=pc+4 (mod 2^32 wrap).
REQ-022 In FETCH with im_ready=0 and branch_taken=1, the block SHALL set redirect_pc<=branch_target, load a bubble, and go to DROP.
REQ-023 In FETCH with im_ready=0 and branch_taken=0, the block SHALL load a bubble if pc_stall=0 and hold the IF registers if pc_stall=1.
REQ-024 In DROP, the block SHALL keep presenting the old pc until im_ready, discard that response, set pc<=redirect_pc and go to FETCH; IF_valid SHALL be 0 in this state.
REQ-025 In DROP, a further branch_taken SHALL overwrite redirect_pc with the newest branch_target.
REQ-026 In HOLD with branch_taken=1, the block SHALL discard hold_instr, set pc<=branch_target, load a bubble, and go to FETCH.
REQ-027 In HOLD with branch_taken=0 and pc_stall=0, the block SHALL set IF_pc_out<=pc, IF_instr_out<=hold_instr, IF_valid<=1, pc<=pc+4, and go to FETCH.
REQ-028 In HOLD with pc_stall=1, the block SHALL keep all registers unchanged.
REQ-029 The block SHALL have a latency of one cycle from the completing im_ready edge to the instruction appearing on IF_instr_out when not stalled.
REQ-030 The block SHALL sustain throughput of one instruction per cycle when im_ready is tied high and no stall or branch occurs.
REQ-031 The block SHALL pass branch_target unmodified, with no alignment correction.

Reset
REQ-032 On rst=1, the block SHALL asynchronously set state=FETCH, pc=RESET_PC, redirect_pc=0, hold_instr=0, IF_pc_out=0, IF_instr_out=NOP_INSTR and IF_valid=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the request; instruction memory shares rst, so no stale response arrives after reset.
REQ-034 On the first cycle after rst deasserts, the block SHALL drive im_req=1 and im_addr=RESET_PC.

Verification
REQ-035 Bench scenario, streaming: im_ready=1 tied, 4 cycles -> IF_pc_out 0,4,8,C on consecutive cycles with IF_valid=1.
REQ-036 Bench scenario, wait states: im_ready low 2 cycles per fetch -> each instruction is preceded by 2 bubbles (IF_valid=0, NOP 0x13); im_addr is stable during the wait.
REQ-037 Bench scenario, stall: pc_stall high 3 cycles while data returns at pc=8 -> IF holds pc=4; after release IF shows pc=8 with the captured data, and im_req=0 while in HOLD.
REQ-038 Bench scenario, redirect in flight: branch_taken with target 0x100 while waiting at pc=0xC -> im_addr stays 0xC until ready, the response is dropped, the next im_addr=0x100, and IF_valid=0 throughout.
REQ-039 Bench scenario, branch and stall together: branch_taken and pc_stall both high in HOLD -> buffer discarded, next fetch at target, bubble delivered.
REQ-040 Bench scenario, reset mid-wait: rst pulsed during an outstanding fetch -> all outputs take their REQ-032 values immediately, and the first request after reset goes to RESET_PC.
